// File: rtl/test_card_pkg.sv
// Shared types and widths for the test card sequencer: FSM encoding and
// RGB channel geometry.
package test_card_pkg;

   typedef enum logic [1:0] {
      SHOW     = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } seq_state_t;

   localparam int SHIFT_MAX = 8;
   localparam int SHIFT_W   = 4;
   localparam int RGB_W     = 24;
   localparam int CHAN_W    = 8;
   localparam int NUM_CHAN  = RGB_W / CHAN_W;

endpackage

// File: rtl/test_card_sequencer_if.sv
// Pixel-side bundle of the sequencer: frame/DE/request inputs from the card
// generators and controls, dimmed RGB plus status towards the encoder.
interface test_card_sequencer_if #(
   parameter int CARDS = 4
);
   import test_card_pkg::*;

   localparam int CARD_W = (CARDS > 1) ? $clog2(CARDS) : 1;

   logic                      i_frame;
   logic                      i_de;
   logic                      i_next;
   logic                      i_auto;
   logic [CARDS*RGB_W-1:0]    i_cards;
   logic [CARD_W-1:0]         o_card;
   logic [CHAN_W-1:0]         o_red;
   logic [CHAN_W-1:0]         o_green;
   logic [CHAN_W-1:0]         o_blue;
   logic                      o_de;
   logic                      o_busy;

   modport master (
      output i_frame, i_de, i_next, i_auto, i_cards,
      input  o_card, o_red, o_green, o_blue, o_de, o_busy
   );

   modport slave (
      input  i_frame, i_de, i_next, i_auto, i_cards,
      output o_card, o_red, o_green, o_blue, o_de, o_busy
   );

endinterface

// File: rtl/card_dimmer.sv
// Per-channel logical right shift of a packed RGB pixel; shifts of 8 or more
// give black.
module card_dimmer
   import test_card_pkg::*;
(
   input  logic [RGB_W-1:0]   rgb,
   input  logic [SHIFT_W-1:0] shift,
   output logic [RGB_W-1:0]   dimmed
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
         assign dimmed[gi*CHAN_W +: CHAN_W] = rgb[gi*CHAN_W +: CHAN_W] >> shift;
      end
   endgenerate

endmodule

// File: rtl/test_card_sequencer.sv
// Selects one of CARDS test card streams, switching only at frame boundaries
// with a frame-paced fade-out / fade-in, triggered manually or by hold timer.
module test_card_sequencer
   import test_card_pkg::*;
#(
   parameter int CARDS       = 4,
   parameter int HOLD_FRAMES = 300,
   parameter int FADE_RATE   = 2
) (
   input  logic                 i_pix_clk,
   input  logic                 i_rst_n,
   test_card_sequencer_if.slave bus
);

   localparam int CARD_W = (CARDS > 1) ? $clog2(CARDS) : 1;
   localparam int HOLD_W = $clog2(HOLD_FRAMES);
   localparam int RATE_W = (FADE_RATE > 1) ? $clog2(FADE_RATE) : 1;

   localparam logic [CARD_W-1:0]  CARD_LAST  = CARD_W'(CARDS - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [RATE_W-1:0]  RATE_LAST  = RATE_W'(FADE_RATE - 1);
   localparam logic [SHIFT_W-1:0] SHIFT_PRE  = SHIFT_W'(SHIFT_MAX - 1);

   seq_state_t          state_reg;
   logic [CARD_W-1:0]   card_reg;
   logic [SHIFT_W-1:0]  shift_reg;
   logic [HOLD_W-1:0]   hold_cnt_reg;
   logic [RATE_W-1:0]   rate_cnt_reg;
   logic                pending_reg;
   logic                busy_reg;

   logic [CHAN_W-1:0]   red_reg;
   logic [CHAN_W-1:0]   green_reg;
   logic [CHAN_W-1:0]   blue_reg;
   logic                de_reg;

   logic [RGB_W-1:0]    card_arr [CARDS];
   logic [RGB_W-1:0]    sel_rgb;
   logic [RGB_W-1:0]    dim_rgb;
   logic                show_go;
   logic                rate_step;

   genvar gi;
   generate
      for (gi = 0; gi < CARDS; gi++) begin : g_card
         assign card_arr[gi] = bus.i_cards[gi*RGB_W +: RGB_W];
      end
   endgenerate

   assign sel_rgb = card_arr[card_reg];

   card_dimmer u_dimmer (
      .rgb    (sel_rgb),
      .shift  (shift_reg),
      .dimmed (dim_rgb)
   );

   // A request arriving together with the frame pulse is serviced directly.
   assign show_go   = pending_reg || bus.i_next ||
                      (bus.i_auto && (hold_cnt_reg == HOLD_LAST));
   assign rate_step = (rate_cnt_reg == RATE_LAST);

   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= SHOW;
         card_reg     <= '0;
         shift_reg    <= '0;
         hold_cnt_reg <= '0;
         rate_cnt_reg <= '0;
         pending_reg  <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         if (bus.i_next) begin
            pending_reg <= 1'b1;
         end
         if (bus.i_frame) begin
            case (state_reg)
               SHOW: begin
                  if (show_go) begin
                     state_reg    <= FADE_OUT;
                     busy_reg     <= 1'b1;
                     hold_cnt_reg <= '0;
                     rate_cnt_reg <= '0;
                     // A fresh request only survives entry if an older one was consumed.
                     pending_reg  <= pending_reg & bus.i_next;
                  end else if (bus.i_auto) begin
                     hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                  end
               end
               FADE_OUT: begin
                  if (rate_step) begin
                     rate_cnt_reg <= '0;
                     shift_reg    <= shift_reg + SHIFT_W'(1);
                     if (shift_reg == SHIFT_PRE) begin
                        card_reg  <= (card_reg == CARD_LAST) ? '0 : card_reg + CARD_W'(1);
                        state_reg <= FADE_IN;
                     end
                  end else begin
                     rate_cnt_reg <= rate_cnt_reg + RATE_W'(1);
                  end
               end
               FADE_IN: begin
                  if (rate_step) begin
                     rate_cnt_reg <= '0;
                     shift_reg    <= shift_reg - SHIFT_W'(1);
                     if (shift_reg == SHIFT_W'(1)) begin
                        state_reg    <= SHOW;
                        busy_reg     <= 1'b0;
                        hold_cnt_reg <= '0;
                     end
                  end else begin
                     rate_cnt_reg <= rate_cnt_reg + RATE_W'(1);
                  end
               end
               default: begin
                  state_reg <= SHOW;
                  busy_reg  <= 1'b0;
                  shift_reg <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         red_reg   <= '0;
         green_reg <= '0;
         blue_reg  <= '0;
         de_reg    <= 1'b0;
      end else begin
         red_reg   <= dim_rgb[2*CHAN_W +: CHAN_W];
         green_reg <= dim_rgb[CHAN_W +: CHAN_W];
         blue_reg  <= dim_rgb[0 +: CHAN_W];
         de_reg    <= bus.i_de;
      end
   end

   assign bus.o_card  = card_reg;
   assign bus.o_red   = red_reg;
   assign bus.o_green = green_reg;
   assign bus.o_blue  = blue_reg;
   assign bus.o_de    = de_reg;
   assign bus.o_busy  = busy_reg;

endmodule
